// File: rtl/stream_demux_pkg.sv
// Shared constants, slot operation encoding and select-range helper for stream_demux.
// Optional per-channel beat counters are enabled with STREAM_DEMUX_CNT_EN.
package stream_demux_pkg;

  localparam int unsigned NUM_OUT_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    SLOT_HOLD,
    SLOT_LOAD,
    SLOT_DRAIN
  } slot_op_e;

  // True when sel addresses an existing channel of an n-channel demux.
  function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
    return sel < n;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// One output channel of stream_demux: a single valid/data register with load and drain.
// With STREAM_DEMUX_CNT_EN a delivered-beat counter with synchronous clear is added.
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef STREAM_DEMUX_CNT_EN
  ,
  parameter int unsigned CNT_W  = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              free
`ifdef STREAM_DEMUX_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  count
`endif
);

  slot_op_e op;

  assign free = !valid || ready;

  // A load always wins: it covers both an empty slot and a same-cycle drain+refill.
  always_comb begin
    op = SLOT_HOLD;
    if (load) begin
      op = SLOT_LOAD;
    end else if (valid && ready) begin
      op = SLOT_DRAIN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      case (op)
        SLOT_LOAD: begin
          valid <= 1'b1;
          data  <= load_data;
        end
        SLOT_DRAIN: valid <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (cnt_clr) begin
      count <= '0;
    end else if (valid && ready) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/stream_demux.sv
// 1:NUM_OUT valid/ready stream demultiplexer with one registered slot per channel.
// Define STREAM_DEMUX_CNT_EN to add cnt_clr and per-channel out_count beat counters.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int unsigned NUM_OUT = NUM_OUT_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned SEL_W   = $clog2(NUM_OUT),
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [SEL_W-1:0]          in_sel,
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic                      drop
`ifdef STREAM_DEMUX_CNT_EN
  ,
  input  logic                      cnt_clr,
  output logic [NUM_OUT*CNT_W-1:0]  out_count
`endif
);

  logic [NUM_OUT-1:0] free;
  logic [NUM_OUT-1:0] load;
  logic               sel_ok;
  logic               accept;

  assign sel_ok = sel_in_range(32'(in_sel), NUM_OUT);

  // Out-of-range selects never match a channel, so in_ready stays 1 for them.
  always_comb begin
    in_ready = 1'b1;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      if (in_sel == SEL_W'(k)) begin
        in_ready = free[k];
      end
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < NUM_OUT; k++) begin
      load[k] = accept && (in_sel == SEL_W'(k));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop <= 1'b0;
    end else begin
      drop <= accept && !sel_ok;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W(DATA_W)
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .CNT_W (CNT_W)
`endif
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[k]),
      .load_data(in_data),
      .ready    (out_ready[k]),
      .valid    (out_valid[k]),
      .data     (out_data[k*DATA_W +: DATA_W]),
      .free     (free[k])
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .cnt_clr  (cnt_clr),
      .count    (out_count[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux (NUM_OUT=3 so out-of-range selects are exercised).
// Counter checks are included when STREAM_DEMUX_CNT_EN is defined.
module tb_stream_demux;

  localparam int N  = 3;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [SW-1:0]   in_sel;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*DW-1:0] out_data;
  logic            drop;
  logic            cnt_clr;
`ifdef STREAM_DEMUX_CNT_EN
  logic [N*CW-1:0] out_count;
`endif

  stream_demux #(
    .NUM_OUT(N),
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .drop     (drop)
`ifdef STREAM_DEMUX_CNT_EN
    ,
    .cnt_clr  (cnt_clr),
    .out_count(out_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: beats accepted but not yet handed to the consumer, per channel.
  logic [DW-1:0] q[N][$];
  bit            exp_rdy_s;
  bit            drop_exp;
  int            cnt[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the model, then retire handshaken beats.
  int  m_sel;
  bit  m_ev;
  always @(negedge clk) begin
    if (!rst) begin
      m_sel = int'(in_sel);
      exp_rdy_s = (m_sel >= N) ? 1'b1 : (q[m_sel].size() == 0 || out_ready[m_sel]);
      check("in_ready", in_ready, exp_rdy_s);
      check("drop", drop, drop_exp);
      for (int k = 0; k < N; k++) begin
        m_ev = q[k].size() != 0;
        check($sformatf("out_valid[%0d]", k), out_valid[k], m_ev);
        if (m_ev) check($sformatf("out_data[%0d]", k), out_data[k*DW +: DW], q[k][0]);
`ifdef STREAM_DEMUX_CNT_EN
        check($sformatf("out_count[%0d]", k), out_count[k*CW +: CW], cnt[k] % (1 << CW));
        if (cnt_clr) cnt[k] = 0;
        else if (m_ev && out_ready[k]) cnt[k] = (cnt[k] + 1) % (1 << CW);
`endif
        if (m_ev && out_ready[k]) void'(q[k].pop_front());
      end
    end
  end

  // Stimulus-side scoreboard feed: record accepted beats after the monitor has retired old ones.
  always @(negedge clk) begin
    #1;
    if (!rst) begin
      drop_exp = in_valid && exp_rdy_s && (int'(in_sel) >= N);
      if (in_valid && exp_rdy_s && int'(in_sel) < N) q[in_sel].push_back(in_data);
    end else begin
      drop_exp = 1'b0;
    end
  end

  task automatic drive(input logic v, input int sel, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    in_valid = v;
    in_sel   = SW'(sel);
    in_data  = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0, '0);
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) begin
      q[k].delete();
      cnt[k] = 0;
    end
    drop_exp = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '1; cnt_clr = 1'b0;
    clear_model();
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop", drop, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Sweep: back-to-back beats to every channel, plus a second beat on ch0.
    drive(1'b1, 0, 8'h11);
    drive(1'b1, 1, 8'h22);
    drive(1'b1, 2, 8'h33);
    drive(1'b1, 0, 8'h44);
    idle(2);

    // Backpressure on ch1.
    out_ready[1] = 1'b0;
    drive(1'b1, 1, 8'h5A);
    drive(1'b1, 1, 8'h6B);
    #1;
    check("bp_in_ready", in_ready, 0);
    check("bp_hold", out_data[1*DW +: DW], 8'h5A);
    @(posedge clk); #1;
    @(posedge clk); #1 out_ready[1] = 1'b1;
    idle(1);
    #1 check("bp_refill", {out_valid[1], out_data[1*DW +: DW]}, {1'b1, 8'h6B});
    idle(2);

    // Independence: ch0 stalled while other channels flow.
    out_ready[0] = 1'b0;
    drive(1'b1, 0, 8'h01);
    drive(1'b1, 2, 8'h02);
    drive(1'b1, 1, 8'h03);
    idle(1);
    #1 check("ind_ch0", {out_valid[0], out_data[0 +: DW]}, {1'b1, 8'h01});
    out_ready[0] = 1'b1;
    idle(2);

    // Drop: select beyond the last channel.
    drive(1'b1, 3, 8'hFF);
    #1 check("drop_in_ready", in_ready, 1);
    idle(1);
    #1 check("drop_pulse", drop, 1);
    idle(1);
    #1 check("drop_end", drop, 0);
    idle(1);

`ifdef STREAM_DEMUX_CNT_EN
    cnt_clr = 1'b1;
    idle(1);
    #1 cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) drive(1'b1, 2, 8'(i));
    idle(2);
    #1 check("cnt_wrap", out_count[2*CW +: CW], 1);
    drive(1'b1, 2, 8'h77);
    idle(1);
    #1 cnt_clr = 1'b1;
    idle(1);
    #1 cnt_clr = 1'b0;
    check("cnt_clr_wins", out_count[2*CW +: CW], 0);
`endif

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      in_valid  = $urandom_range(0, 3) != 0;
      in_sel    = SW'($urandom_range(0, 3));
      in_data   = DW'($urandom);
      out_ready = N'($urandom);
`ifdef STREAM_DEMUX_CNT_EN
      cnt_clr   = $urandom_range(0, 19) == 0;
`endif
    end
    @(posedge clk); #1 in_valid = 1'b0; cnt_clr = 1'b0; out_ready = '1;
    idle(2);

    // Asynchronous reset while ch2 holds a stalled beat.
    out_ready[2] = 1'b0;
    drive(1'b1, 2, 8'hA5);
    @(posedge clk); #1 in_valid = 1'b0;
    #1 check("pre_rst_hold", {out_valid[2], out_data[2*DW +: DW]}, {1'b1, 8'hA5});
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_drop", drop, 0);
`ifdef STREAM_DEMUX_CNT_EN
    check("async_rst_count", out_count, 0);
`endif
    clear_model();
    out_ready = '1;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    drive(1'b1, 1, 8'h3C);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
